seg_bcd_fmt: RTL and testbench



---
 rtl/seg_pkg.sv | 38 +++
 rtl/seg_bcd_fmt_if.sv | 29 ++
 rtl/bcd_add3.sv | 13 +
 rtl/seg_bcd_fmt.sv | 108 ++++++++++
 tb/tb_seg_bcd_fmt.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment display path: digit codes understood
// by the serial driver's decoder, formatter FSM states, the default overflow limit
// and a leading-zero blanking helper.
package seg_pkg;

  // Digit codes 0-9 are plain numerals.
  localparam logic [3:0] DIG_A     = 4'd10;
  localparam logic [3:0] DIG_H     = 4'd11;
  localparam logic [3:0] DIG_C     = 4'd12;
  localparam logic [3:0] DIG_BLANK = 4'hF;

  // Largest value that fits on four decimal digits.
  localparam int unsigned MAXVAL_DEF = 9999;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FMT   = 2'd2
  } state_t;

  // Replace leading zero digits (digit3 downwards) with blanks. Digit0 is
  // always kept so that zero still shows as a single "0".
  function automatic logic [15:0] blank_lead(input logic [15:0] w);
    logic [15:0] r;
    logic        lead;
    r    = w;
    lead = 1'b1;
    for (int i = 3; i >= 1; i--) begin
      if (lead && (w[4*i +: 4] == 4'd0)) begin
        r[4*i +: 4] = DIG_BLANK;
      end else begin
        lead = 1'b0;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/seg_bcd_fmt_if.sv
// Request/result bundle between a measurement source and the display formatter.
//   load     : start request (source -> formatter)
//   value    : unsigned binary value, WIDTH bits (source -> formatter)
//   blank_en : blank leading zeros for this request (source -> formatter)
//   busy     : conversion in progress (formatter -> source)
//   done     : one-cycle completion pulse (formatter -> source)
//   disnum   : packed digit word {d3,d2,d1,d0} (formatter -> driver)
interface seg_bcd_fmt_if #(
  parameter int unsigned WIDTH = 14
) ();

  logic             load;
  logic [WIDTH-1:0] value;
  logic             blank_en;
  logic             busy;
  logic             done;
  logic [15:0]      disnum;

  modport master (
    output load, value, blank_en,
    input  busy, done, disnum
  );

  modport slave (
    input  load, value, blank_en,
    output busy, done, disnum
  );

endinterface

// File: rtl/bcd_add3.sv
// Per-nibble double-dabble correction: adds 3 to a BCD digit that is 5 or more,
// so that the following left shift carries correctly into the next digit.
// Arithmetic wraps on 4 bits; no carry leaves the nibble.
//   in_i  : current BCD nibble
//   out_o : corrected nibble
module bcd_add3 (
  input  logic [3:0] in_i,
  output logic [3:0] out_o
);

  assign out_o = (in_i >= 4'd5) ? (in_i + 4'd3) : in_i;

endmodule

// File: rtl/seg_bcd_fmt.sv
// Binary-to-display formatter feeding the 4-digit serial seven-segment driver.
// Converts an unsigned binary value to four BCD digits one bit per clock
// (shift-and-add-3), then applies overflow marking ("HHHH") or leading-zero
// blanking and updates disnum in a single edge.
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : seg_bcd_fmt_if slave (load/value/blank_en in, busy/done/disnum out)
module seg_bcd_fmt
  import seg_pkg::*;
#(
  parameter int unsigned WIDTH  = 14,
  parameter int unsigned MAXVAL = MAXVAL_DEF
) (
  input logic          clk,
  input logic          rst,
  seg_bcd_fmt_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_t           state_q;
  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] bin_d;
  logic [15:0]      bcd_q;
  logic [15:0]      bcd_adj;
  logic [15:0]      bcd_d;
  logic [CW-1:0]    cnt_q;
  logic             blank_q;
  logic             ovf_q;
  logic             busy_q;
  logic             done_q;
  logic [15:0]      disnum_q;
  logic [15:0]      fmt_d;

  // Digit correctors, one per BCD nibble.
  for (genvar g = 0; g < 4; g++) begin : g_add3
    bcd_add3 u_add3 (
      .in_i  (bcd_q[4*g +: 4]),
      .out_o (bcd_adj[4*g +: 4])
    );
  end

  // One double-dabble step and the final display word.
  always_comb begin
    bcd_d = (bcd_adj << 1) | 16'(bin_q[WIDTH-1]);
    bin_d = bin_q << 1;
    if (ovf_q) begin
      fmt_d = {4{DIG_H}};
    end else if (blank_q) begin
      fmt_d = blank_lead(bcd_q);
    end else begin
      fmt_d = bcd_q;
    end
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      blank_q  <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      disnum_q <= {4{DIG_BLANK}};
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.load) begin
            bin_q   <= bus.value;
            blank_q <= bus.blank_en;
            // Overflow is judged on the binary input, not on the BCD result.
            ovf_q   <= (32'(bus.value) > MAXVAL);
            bcd_q   <= '0;
            cnt_q   <= CW'(WIDTH - 1);
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_q <= bcd_d;
          bin_q <= bin_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == '0) begin
            busy_q  <= 1'b0;
            state_q <= FMT;
          end
        end
        FMT: begin
          disnum_q <= fmt_d;
          done_q   <= 1'b1;
          state_q  <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.disnum = disnum_q;

endmodule

// File: tb/tb_seg_bcd_fmt.sv
// Bench for seg_bcd_fmt: a cycle-level reference model derived from the
// conversion latency and the decimal value, compared on every falling edge,
// plus directed scenarios with literal expected display words.
module tb_seg_bcd_fmt;

  localparam int unsigned WIDTH = 14;
  localparam int          LAT   = WIDTH + 1;

  logic clk = 1'b0;
  logic rst;

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit chk_en    = 1'b0;

  seg_bcd_fmt_if #(.WIDTH(WIDTH)) bus ();

  seg_bcd_fmt #(.WIDTH(WIDTH), .MAXVAL(9999)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // Expected display word from the decimal value.
  function automatic logic [15:0] exp_word(input int v, input bit blank);
    logic [15:0] w;
    int p;
    w = 16'h0;
    if (v > 9999) return 16'hBBBB;
    p = 1;
    for (int i = 0; i < 4; i++) begin
      if (blank && i > 0 && v < p) w[4*i +: 4] = 4'hF;
      else w[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return w;
  endfunction

  // Reference model: a request accepted while idle completes LAT edges later;
  // busy drops one edge earlier.
  bit          m_active;
  int          m_age;
  int          m_val;
  bit          m_blank;
  logic        m_busy;
  logic        m_done;
  logic [15:0] m_disnum;

  always @(posedge clk) begin
    if (rst) begin
      m_active = 1'b0;
      m_age    = 0;
      m_busy   = 1'b0;
      m_done   = 1'b0;
      m_disnum = 16'hFFFF;
    end else begin
      m_done = 1'b0;
      if (m_active) begin
        m_age++;
        if (m_age == LAT - 1) m_busy = 1'b0;
        if (m_age == LAT) begin
          m_disnum = exp_word(m_val, m_blank);
          m_done   = 1'b1;
          m_active = 1'b0;
        end
      end else if (bus.load) begin
        m_active = 1'b1;
        m_age    = 0;
        m_val    = int'(bus.value);
        m_blank  = bus.blank_en;
        m_busy   = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_busy", 16'(bus.busy), 16'(m_busy));
      check("model_done", 16'(bus.done), 16'(m_done));
      check("model_disnum", bus.disnum, m_disnum);
      if (bus.busy && bus.done) check("busy_and_done", 16'd1, 16'd0);
    end
  end

  // One conversion: checks latency, busy length and the literal result.
  task automatic run(input int v, input bit b, input logic [15:0] lit, input string nm);
    int k;
    int bz;
    bit seen;
    @(negedge clk);
    bus.load     = 1'b1;
    bus.value    = 14'(v);
    bus.blank_en = b;
    @(negedge clk);
    bus.load = 1'b0;
    k    = 1;
    bz   = bus.busy ? 1 : 0;
    seen = 1'b0;
    while (!seen && k < 40) begin
      if (bus.done) seen = 1'b1;
      else begin
        @(negedge clk);
        k++;
        if (bus.busy) bz++;
      end
    end
    check({nm, "_done_seen"}, 16'(seen), 16'd1);
    check({nm, "_latency"}, 16'(k - 1), 16'(LAT));
    check({nm, "_busy_cycles"}, 16'(bz), 16'(WIDTH));
    check({nm, "_disnum"}, bus.disnum, lit);
    @(negedge clk);
    check({nm, "_done_pulse"}, 16'(bus.done), 16'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    int last_k;
    int gap_checks;
    rst          = 1'b1;
    bus.load     = 1'b0;
    bus.value    = '0;
    bus.blank_en = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_disnum", bus.disnum, 16'hFFFF);
    check("reset_busy", 16'(bus.busy), 16'd0);
    check("reset_done", 16'(bus.done), 16'd0);
    rst    = 1'b0;
    chk_en = 1'b1;

    // Model self-pins.
    check("model_pin_1234", exp_word(1234, 1'b0), 16'h1234);
    check("model_pin_0", exp_word(0, 1'b1), 16'hFFF0);
    check("model_pin_1005", exp_word(1005, 1'b1), 16'h1005);

    run(1234, 1'b0, 16'h1234, "v1234");
    run(7, 1'b1, 16'hFFF7, "v7");
    run(0, 1'b1, 16'hFFF0, "v0");
    run(1005, 1'b1, 16'h1005, "v1005");
    run(9999, 1'b0, 16'h9999, "v9999");
    run(10000, 1'b0, 16'hBBBB, "v10000");
    run(16383, 1'b1, 16'hBBBB, "v16383");
    run(40, 1'b0, 16'h0040, "v40_noblank");

    // Second load 5 cycles in is ignored.
    @(negedge clk);
    bus.load = 1'b1; bus.value = 14'(3210); bus.blank_en = 1'b0;
    @(negedge clk);
    bus.load = 1'b0;
    dones = 0;
    repeat (4) @(negedge clk);
    bus.load = 1'b1; bus.value = 14'(42);
    @(negedge clk);
    bus.load = 1'b0;
    if (bus.done) dones++;
    repeat (30) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("ignored_load_dones", 16'(dones), 16'd1);
    check("ignored_load_disnum", bus.disnum, 16'h3210);

    // Reset mid-conversion aborts without done.
    @(negedge clk);
    bus.load = 1'b1; bus.value = 14'(4321); bus.blank_en = 1'b0;
    @(negedge clk);
    bus.load = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 16'(bus.busy), 16'd0);
    check("abort_disnum", bus.disnum, 16'hFFFF);
    rst   = 1'b0;
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("abort_no_done", 16'(dones), 16'd0);
    run(4321, 1'b0, 16'h4321, "v4321_after_abort");

    // Load held high: back-to-back conversions every LAT+1 clocks.
    @(negedge clk);
    bus.load = 1'b1; bus.value = 14'(56); bus.blank_en = 1'b1;
    last_k     = -1;
    gap_checks = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (bus.done) begin
        check("held_disnum", bus.disnum, 16'hFF56);
        if (last_k >= 0) begin
          check("held_period", 16'(k - last_k), 16'(LAT + 1));
          gap_checks++;
        end
        last_k = k;
      end
    end
    check("held_enough_pulses", 16'(gap_checks >= 2), 16'd1);
    bus.load = 1'b0;
    repeat (20) @(negedge clk);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
